if_fetch: RTL and testbench
===========================

Name: if_fetch

Overview:
- Instruction fetch stage that sits directly upstream of the IF/ID pipeline register.
- Generates the PC and issues one-outstanding request/grant/response transactions to instruction memory.
- Buffers returned instructions in a 2-entry FIFO and presents {if_pc, if_inst, ifid_wd} to IF/ID.
- Handles downstream stalls and branch redirects, including discarding stale responses.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- ADDR_W, 32, PC/address width.
- INST_W, 32, instruction width.

Ports:
- clk  in  1  system clock, all state updates on its rising edge.
- rst  in  1  reset, asynchronous, active-low.
- stall_i  in  1  downstream stall; 1 means IF/ID does not accept this cycle.
- branch_flag_i  in  1  redirect pulse from ID.
- branch_target_i  in  ADDR_W  redirect address, valid when branch_flag_i=1.
- imem_req_o  out  1  memory request valid.
- imem_addr_o  out  ADDR_W  request address, word aligned.
- imem_gnt_i  in  1  memory accepts the request this cycle.
- imem_rvalid_i  in  1  response valid; responses are in order, at least 1 cycle after gnt.
- imem_rdata_i  in  INST_W  response instruction.
- if_pc  out  ADDR_W  PC of the FIFO head.
- if_inst  out  INST_W  instruction at the FIFO head.
- ifid_wd  out  1  head valid / IF/ID write enable.

Behaviour:
- Reset (rst=0, async):
  - pc=RESET_PC; FIFO empty; occupancy=0; outstanding=0; drop=0; state=IDLE.
  - imem_req_o=0, imem_addr_o=RESET_PC, if_pc=0, if_inst=0, ifid_wd=0.
  - Reset mid-transaction abandons all state; a late rvalid after reset, with outstanding=0, is ignored.
- FSM states:
  - IDLE → REQ when occupancy+outstanding<2. The first REQ cycle is the first clk edge after rst deasserts.
  - REQ: imem_req_o=1, imem_addr_o=pc. On gnt → WAIT with outstanding=1, and pc<=pc+4 unless a redirect applies.
  - WAIT: on rvalid → REQ if there is FIFO space after this cycle's push/pop, else IDLE.
- Request handshake:
  - imem_addr_o must remain stable while imem_req_o=1 and gnt=0; the request is never retracted.
- Response:
  - On rvalid with drop=0: push {issued_pc, rdata} into the FIFO and clear outstanding.
  - On rvalid with drop=1: discard the data and clear both drop and outstanding.
- Output:
  - if_pc/if_inst = FIFO head, or 0 when the FIFO is empty.
  - ifid_wd = (FIFO non-empty) & ~branch_flag_i, combinational.
  - Pop the head when ifid_wd=1 and stall_i=0.
- Latency:
  - gnt in cycle N and rvalid in cycle N+1 → ifid_wd=1 in cycle N+2.
  - Best-case steady throughput is 1 instruction per 2 cycles.
- Branch (branch_flag_i=1 in a cycle):
  - Flush the FIFO (occupancy=0); no pop occurs.
  - pc <= {branch_target_i[ADDR_W-1:2], 2'b00}; low 2 bits are forced to zero.
  - If a request is outstanding, or is granted this same cycle, set drop=1.
  - If in REQ without gnt, the pending request is completed unchanged and its response is dropped. The target is fetched in the next REQ.
  - If branch and rvalid occur in the same cycle, the response is dropped and not pushed.
- Boundaries:
  - Push and pop in the same cycle: legal; occupancy is unchanged.
  - Overflow is impossible because issue is gated by occupancy+outstanding<2.
  - rvalid with outstanding=0 is ignored.
  - PC wraps modulo 2^ADDR_W: 32'hFFFF_FFFC+4 = 0.

Test Plan:
- Reset then free-running memory (gnt same cycle, rvalid next cycle), stall_i=0:
  - Required: addresses 0,4,8 requested; ifid_wd pulses with if_pc=0,4,8 and matching if_inst.
  - Required: first ifid_wd=1 exactly 3 cycles after rst rises.
- stall_i=1 held for 6 cycles:
  - Required: FIFO fills to 2 entries (pc 0,4); no third request is issued.
  - Required: if_pc holds 0 with ifid_wd=1.
  - Release stall → pops 0 then 4, and fetching resumes at 8.
- Redirect to 32'h0000_0103 while the response for 8 is outstanding:
  - Required: response for 8 is discarded; FIFO flushed; ifid_wd=0 that cycle.
  - Required: next request address is 32'h0000_0100.
- branch_flag_i and imem_rvalid_i in the same cycle:
  - Required: data is not pushed; ifid_wd stays 0 until the target's response arrives.
- gnt withheld 4 cycles:
  - Required: imem_req_o=1 with imem_addr_o stable throughout; a branch during the wait still yields exactly one request to the old address (response dropped), then one to the target.
- Assert rst=0 asynchronously mid-WAIT:
  - Required: all outputs reach reset values without a clock edge.
  - Required: a late rvalid is ignored; the first request after release is to RESET_PC.

Source files
------------

// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - instruction fetch stage: PC generation, one-outstanding imem fetch, 2-entry buffer to IF/ID
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 32,
  parameter int          INST_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_gnt_i,
  input  logic              imem_rvalid_i,
  input  logic [INST_W-1:0] imem_rdata_i,
  output logic [ADDR_W-1:0] if_pc,
  output logic [INST_W-1:0] if_inst,
  output logic              ifid_wd
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t              state, state_next;
  logic [ADDR_W-1:0]   pc;
  logic [ADDR_W-1:0]   issued_pc;
  logic [ADDR_W-1:0]   pend_pc;
  logic                pend_vld;
  logic                outstanding;
  logic                drop;
  logic [ADDR_W-1:0]   fifo_pc   [2];
  logic [INST_W-1:0]   fifo_inst [2];
  logic                rd_ptr, wr_ptr;
  logic [1:0]          count, count_next;

  logic [ADDR_W-1:0]   br_pc;
  logic                granted, resp, push, pop;
  logic                unused_tgt_lo;

  assign br_pc         = {branch_target_i[ADDR_W-1:2], 2'b00};
  assign unused_tgt_lo = ^branch_target_i[1:0];
  assign granted       = (state == REQ) && imem_gnt_i;
  // A response only counts when we are actually waiting for one.
  assign resp          = imem_rvalid_i && outstanding;
  assign push          = resp && !drop && !branch_flag_i;
  assign ifid_wd       = (count != 2'd0) && !branch_flag_i;
  assign pop           = ifid_wd && !stall_i;

  assign imem_req_o  = (state == REQ);
  assign imem_addr_o = pc;
  assign if_pc       = (count != 2'd0) ? fifo_pc[rd_ptr]   : '0;
  assign if_inst     = (count != 2'd0) ? fifo_inst[rd_ptr] : '0;

  always_comb begin
    count_next = count;
    if (branch_flag_i)
      count_next = 2'd0;
    else
      count_next = count + {1'b0, push} - {1'b0, pop};
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if ((count + {1'b0, outstanding}) < 2'd2) state_next = REQ;
      REQ:  if (imem_gnt_i) state_next = WAIT;
      WAIT: if (resp) state_next = (count_next < 2'd2) ? REQ : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      count <= 2'd0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr       <= 1'b0;
      wr_ptr       <= 1'b0;
      fifo_pc[0]   <= '0;
      fifo_pc[1]   <= '0;
      fifo_inst[0] <= '0;
      fifo_inst[1] <= '0;
    end else if (branch_flag_i) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      if (push) begin
        fifo_pc[wr_ptr]   <= issued_pc;
        fifo_inst[wr_ptr] <= imem_rdata_i;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop)
        rd_ptr <= ~rd_ptr;
    end
  end

  // A redirect seen while a request is still waiting for gnt is parked in
  // pend_pc so the presented address stays stable until the grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc          <= RESET_PC[ADDR_W-1:0];
      issued_pc   <= RESET_PC[ADDR_W-1:0];
      pend_pc     <= '0;
      pend_vld    <= 1'b0;
      outstanding <= 1'b0;
      drop        <= 1'b0;
    end else begin
      if (granted) begin
        issued_pc <= pc;
        pend_vld  <= 1'b0;
        if (branch_flag_i)
          pc <= br_pc;
        else if (pend_vld)
          pc <= pend_pc;
        else
          pc <= pc + ADDR_W'(4);
      end else if (branch_flag_i) begin
        if (state == REQ) begin
          pend_vld <= 1'b1;
          pend_pc  <= br_pc;
        end else begin
          pc <= br_pc;
        end
      end

      if (granted)
        outstanding <= 1'b1;
      else if (resp)
        outstanding <= 1'b0;

      if (branch_flag_i && ((state == REQ) || (outstanding && !resp)))
        drop <= 1'b1;
      else if (resp)
        drop <= 1'b0;
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// tb/tb_if_fetch.sv - directed self-checking bench for if_fetch
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall_i = 1'b0;
  logic        branch_flag_i = 1'b0;
  logic [31:0] branch_target_i = '0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        ifid_wd;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  int          rv_lat = 1;
  int          hold   = 0;
  int          rv_wait = 0;
  bit          rv_pend = 1'b0;
  logic [31:0] rv_addr = '0;
  logic [31:0] glog [$];

  if_fetch #(.RESET_PC(32'h0000_0000), .ADDR_W(32), .INST_W(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .stall_i         (stall_i),
    .branch_flag_i   (branch_flag_i),
    .branch_target_i (branch_target_i),
    .imem_req_o      (imem_req_o),
    .imem_addr_o     (imem_addr_o),
    .imem_gnt_i      (imem_gnt_i),
    .imem_rvalid_i   (imem_rvalid_i),
    .imem_rdata_i    (imem_rdata_i),
    .if_pc           (if_pc),
    .if_inst         (if_inst),
    .ifid_wd         (ifid_wd)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp)
      pass_cnt++;
    else
      $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  // Memory: grants when not held off, answers rv_lat cycles after the grant.
  initial begin
    forever begin
      @(negedge clk);
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = '0;
      if (rv_pend) begin
        if (rv_wait == 0) begin
          imem_rvalid_i = 1'b1;
          imem_rdata_i  = inst_of(rv_addr);
          rv_pend       = 1'b0;
        end else begin
          rv_wait--;
        end
      end
      imem_gnt_i = 1'b0;
      if (imem_req_o) begin
        if (hold > 0) begin
          hold--;
        end else begin
          imem_gnt_i = 1'b1;
          glog.push_back(imem_addr_o);
          rv_pend = 1'b1;
          rv_addr = imem_addr_o;
          rv_wait = rv_lat - 1;
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b0;
    cyc();
    cyc();
    check("rst_req",  {31'd0, imem_req_o}, 32'd0);
    check("rst_addr", imem_addr_o, 32'h0);
    check("rst_pc",   if_pc, 32'h0);
    check("rst_inst", if_inst, 32'h0);
    check("rst_wd",   {31'd0, ifid_wd}, 32'd0);
    glog.delete();
    rst = 1'b1;
  endtask

  initial begin
    // free-running memory
    do_reset();
    cyc();
    check("t1_c1_req",  {31'd0, imem_req_o}, 32'd1);
    check("t1_c1_addr", imem_addr_o, 32'h0);
    check("t1_c1_wd",   {31'd0, ifid_wd}, 32'd0);
    cyc();
    check("t1_c2_wd",   {31'd0, ifid_wd}, 32'd0);
    cyc();
    check("t1_c3_wd",   {31'd0, ifid_wd}, 32'd1);
    check("t1_c3_pc",   if_pc, 32'h0);
    check("t1_c3_inst", if_inst, inst_of(32'h0));
    cyc();
    cyc();
    check("t1_c5_wd",   {31'd0, ifid_wd}, 32'd1);
    check("t1_c5_pc",   if_pc, 32'h4);
    check("t1_c5_inst", if_inst, inst_of(32'h4));
    cyc();
    cyc();
    check("t1_c7_pc",   if_pc, 32'h8);
    check("t1_c7_inst", if_inst, inst_of(32'h8));
    check("t1_glog_n",  32'(glog.size()), 32'd4);
    check("t1_glog1",   glog[1], 32'h4);
    check("t1_glog2",   glog[2], 32'h8);

    // stall held for 6 cycles
    stall_i = 1'b1;
    do_reset();
    for (int i = 1; i <= 6; i++) cyc();
    check("t2_req_idle", {31'd0, imem_req_o}, 32'd0);
    check("t2_wd",       {31'd0, ifid_wd}, 32'd1);
    check("t2_pc",       if_pc, 32'h0);
    check("t2_glog_n",   32'(glog.size()), 32'd2);
    check("t2_glog1",    glog[1], 32'h4);
    stall_i = 1'b0;
    cyc();
    check("t2_pop4_pc",  if_pc, 32'h4);
    check("t2_pop4_wd",  {31'd0, ifid_wd}, 32'd1);
    rv_lat = 2;
    cyc();
    check("t2_resume",   imem_addr_o, 32'h8);
    check("t2_resume_r", {31'd0, imem_req_o}, 32'd1);

    // redirect while the response for 8 is outstanding
    cyc();
    branch_flag_i   = 1'b1;
    branch_target_i = 32'h0000_0103;
    #1;
    check("t3_br_wd", {31'd0, ifid_wd}, 32'd0);
    cyc();
    branch_flag_i = 1'b0;
    rv_lat = 1;
    check("t3_rv_wd", {31'd0, ifid_wd}, 32'd0);
    cyc();
    check("t3_req",  {31'd0, imem_req_o}, 32'd1);
    check("t3_addr", imem_addr_o, 32'h0000_0100);
    check("t3_wd",   {31'd0, ifid_wd}, 32'd0);
    cyc();
    cyc();
    check("t3_tgt_pc",   if_pc, 32'h100);
    check("t3_tgt_inst", if_inst, inst_of(32'h100));

    // branch and rvalid in the same cycle
    cyc();
    branch_flag_i   = 1'b1;
    branch_target_i = 32'h0000_0200;
    #1;
    check("t4_br_wd", {31'd0, ifid_wd}, 32'd0);
    cyc();
    branch_flag_i = 1'b0;
    check("t4_wd_a", {31'd0, ifid_wd}, 32'd0);
    check("t4_addr", imem_addr_o, 32'h200);
    cyc();
    check("t4_wd_b", {31'd0, ifid_wd}, 32'd0);
    hold = 4;
    glog.delete();
    cyc();
    check("t4_pc",   if_pc, 32'h200);
    check("t4_inst", if_inst, inst_of(32'h200));

    // gnt withheld 4 cycles, branch during the wait
    for (int i = 0; i < 5; i++) begin
      if (i > 0) cyc();
      branch_flag_i = 1'b0;
      check($sformatf("t5_req_%0d", i),  {31'd0, imem_req_o}, 32'd1);
      check($sformatf("t5_addr_%0d", i), imem_addr_o, 32'h204);
      if (i == 2) begin
        branch_flag_i   = 1'b1;
        branch_target_i = 32'h0000_0300;
      end
    end
    cyc();
    check("t5_drop_wd", {31'd0, ifid_wd}, 32'd0);
    cyc();
    check("t5_tgt_addr", imem_addr_o, 32'h300);
    check("t5_glog_n",   32'(glog.size()), 32'd2);
    check("t5_glog0",    glog[0], 32'h204);
    check("t5_glog1",    glog[1], 32'h300);
    cyc();
    check("t5_wd0", {31'd0, ifid_wd}, 32'd0);
    rv_lat = 3;
    cyc();
    check("t5_pc",   if_pc, 32'h300);
    check("t5_inst", if_inst, inst_of(32'h300));

    // asynchronous reset mid-WAIT, late response afterwards
    cyc();
    #2;
    rst = 1'b0;
    #1;
    check("t6_req",  {31'd0, imem_req_o}, 32'd0);
    check("t6_addr", imem_addr_o, 32'h0);
    check("t6_pc",   if_pc, 32'h0);
    check("t6_inst", if_inst, 32'h0);
    check("t6_wd",   {31'd0, ifid_wd}, 32'd0);
    cyc();
    rv_lat = 1;
    glog.delete();
    rst = 1'b1;
    cyc();
    check("t6_late_rv", {31'd0, imem_rvalid_i}, 32'd1);
    check("t6_glog_n",  32'(glog.size()), 32'd1);
    check("t6_glog0",   glog[0], 32'h0);
    cyc();
    cyc();
    check("t6_wd",      {31'd0, ifid_wd}, 32'd1);
    check("t6_pc0",     if_pc, 32'h0);
    check("t6_inst0",   if_inst, inst_of(32'h0));

    // redirect granted same cycle, low bits forced, PC wrap
    branch_flag_i   = 1'b1;
    branch_target_i = 32'hFFFF_FFFF;
    #1;
    check("t7_br_wd", {31'd0, ifid_wd}, 32'd0);
    cyc();
    branch_flag_i = 1'b0;
    cyc();
    check("t7_addr",  imem_addr_o, 32'hFFFF_FFFC);
    cyc();
    cyc();
    check("t7_wrap",  imem_addr_o, 32'h0);
    check("t7_pc",    if_pc, 32'hFFFF_FFFC);
    check("t7_inst",  if_inst, inst_of(32'hFFFF_FFFC));

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
